// File: rtl/flex_pts_streamer.sv
// -----------------------------------------------------------------------------
// flex_pts_streamer
//
// Parallel-to-serial transmitter with a one-word holding buffer. Words arrive
// over a valid/ready handshake, are parked in hold_reg, then moved into the
// shift register and sent one bit at a time. Bit order, idle line level and
// the number of clocks each bit is held are set by parameters. A word waiting
// in the holding buffer is loaded on the last tick of the current word, so
// back-to-back words leave no idle gap on the line.
//
// Parameters
//   NUM_BITS   : word width (>= 2)
//   SHIFT_MSB  : 1 = MSB first, 0 = LSB first
//   IDLE_VALUE : serial_out level when idle, also the shift-in fill bit
//   BIT_PERIOD : clocks each bit is held on serial_out (>= 1)
//
// Ports
//   clk        in   system clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   data_in    in   word to transmit
//   data_valid in   data_in is valid
//   data_ready out  holding buffer empty (word accepted on valid && ready)
//   flush      in   synchronous abort of buffered and in-flight words
//   serial_out out  registered serial bit stream
//   busy       out  high while a word is being shifted out
//   word_done  out  one-cycle pulse after the last bit period of a word
// -----------------------------------------------------------------------------
module flex_pts_streamer #(
  parameter int   NUM_BITS   = 4,
  parameter bit   SHIFT_MSB  = 1'b1,
  parameter logic IDLE_VALUE = 1'b1,
  parameter int   BIT_PERIOD = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_BITS-1:0] data_in,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic                flush,
  output logic                serial_out,
  output logic                busy,
  output logic                word_done
);

  localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

  localparam logic [BW-1:0]       LAST_BIT  = BW'(NUM_BITS - 1);
  localparam logic [TW-1:0]       LAST_TICK = TW'(BIT_PERIOD - 1);
  localparam logic [NUM_BITS-1:0] FILL      = {NUM_BITS{IDLE_VALUE}};

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state,       state_d;
  logic [NUM_BITS-1:0] hold_reg,    hold_reg_d;
  logic                hold_full,   hold_full_d;
  logic [NUM_BITS-1:0] shift_reg,   shift_reg_d;
  logic [BW-1:0]       bit_cnt,     bit_cnt_d;
  logic [TW-1:0]       tick_cnt,    tick_cnt_d;
  logic                word_done_d;

  logic                accept;
  logic [NUM_BITS-1:0] shifted;

  // Handshake: ready is a pure decode of the buffer flag.
  assign data_ready = !hold_full;
  assign accept     = data_valid && !hold_full;

  // One position toward the output end, idle level filling in behind.
  assign shifted = SHIFT_MSB ? {shift_reg[NUM_BITS-2:0], IDLE_VALUE}
                             : {IDLE_VALUE, shift_reg[NUM_BITS-1:1]};

  assign serial_out = SHIFT_MSB ? shift_reg[NUM_BITS-1] : shift_reg[0];
  assign busy       = (state == SHIFT);

  // Next-state and datapath decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the branches below can leave a signal unassigned (no latches).
    state_d     = state;
    hold_reg_d  = hold_reg;
    hold_full_d = hold_full;
    shift_reg_d = shift_reg;
    bit_cnt_d   = bit_cnt;
    tick_cnt_d  = tick_cnt;
    word_done_d = 1'b0;

    if (flush) begin
      // Abort wins over everything, including an accept on this edge.
      state_d     = IDLE;
      hold_full_d = 1'b0;
      shift_reg_d = FILL;
      bit_cnt_d   = '0;
      tick_cnt_d  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hold_full) begin
            shift_reg_d = hold_reg;
            hold_full_d = 1'b0;
            bit_cnt_d   = '0;
            tick_cnt_d  = '0;
            state_d     = SHIFT;
          end
        end
        SHIFT: begin
          if (tick_cnt != LAST_TICK) begin
            tick_cnt_d = tick_cnt + TW'(1);
          end else if (bit_cnt != LAST_BIT) begin
            shift_reg_d = shifted;
            tick_cnt_d  = '0;
            bit_cnt_d   = bit_cnt + BW'(1);
          end else begin
            // Last tick of the last bit: chain straight into a buffered
            // word if there is one, otherwise return the line to idle.
            word_done_d = 1'b1;
            tick_cnt_d  = '0;
            bit_cnt_d   = '0;
            if (hold_full) begin
              shift_reg_d = hold_reg;
              hold_full_d = 1'b0;
            end else begin
              shift_reg_d = FILL;
              state_d     = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // Accept needs an empty buffer and a drain needs a full one, so the
      // two never collide on the same edge.
      if (accept) begin
        hold_reg_d  = data_in;
        hold_full_d = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: hold_reg is pure data guarded by hold_full; it is reset anyway
      // so no X ever propagates into shift_reg.
      state     <= IDLE;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      shift_reg <= FILL;
      bit_cnt   <= '0;
      tick_cnt  <= '0;
      word_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state     <= state_d;
      hold_reg  <= hold_reg_d;
      hold_full <= hold_full_d;
      shift_reg <= shift_reg_d;
      bit_cnt   <= bit_cnt_d;
      tick_cnt  <= tick_cnt_d;
      word_done <= word_done_d;
    end
  end

endmodule

// File: tb/tb_flex_pts_streamer.sv
// -----------------------------------------------------------------------------
// tb_flex_pts_streamer
//
// Three instances with different parameter sets share one stimulus stream;
// `sel` chooses which instance's outputs are compared in the current phase.
// The reference model represents the line as a queue of expected bit-cycles:
// loading a word appends NUM_BITS*BIT_PERIOD entries, each clock consumes one.
// -----------------------------------------------------------------------------
module tb_flex_pts_streamer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       flush;

  // Instance A: 8 bits, MSB first, idle 1, one clock per bit
  logic rdy_a, so_a, bsy_a, wd_a;
  // Instance B: 8 bits, LSB first, idle 1, three clocks per bit
  logic rdy_b, so_b, bsy_b, wd_b;
  // Instance C: 5 bits, MSB first, idle 0, two clocks per bit
  logic rdy_c, so_c, bsy_c, wd_c;

  always #5 clk = ~clk;

  flex_pts_streamer #(.NUM_BITS(8), .SHIFT_MSB(1'b1), .IDLE_VALUE(1'b1), .BIT_PERIOD(1)) dut_a (
    .clk(clk), .n_rst(n_rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy_a), .flush(flush), .serial_out(so_a), .busy(bsy_a), .word_done(wd_a));

  flex_pts_streamer #(.NUM_BITS(8), .SHIFT_MSB(1'b0), .IDLE_VALUE(1'b1), .BIT_PERIOD(3)) dut_b (
    .clk(clk), .n_rst(n_rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy_b), .flush(flush), .serial_out(so_b), .busy(bsy_b), .word_done(wd_b));

  flex_pts_streamer #(.NUM_BITS(5), .SHIFT_MSB(1'b1), .IDLE_VALUE(1'b0), .BIT_PERIOD(2)) dut_c (
    .clk(clk), .n_rst(n_rst), .data_in(data_in[4:0]), .data_valid(data_valid),
    .data_ready(rdy_c), .flush(flush), .serial_out(so_c), .busy(bsy_c), .word_done(wd_c));

  // Selected instance outputs
  int   sel;
  logic so, rdy, bsy, wd;

  always_comb begin
    so = so_a; rdy = rdy_a; bsy = bsy_a; wd = wd_a;
    case (sel)
      1:       begin so = so_b; rdy = rdy_b; bsy = bsy_b; wd = wd_b; end
      2:       begin so = so_c; rdy = rdy_c; bsy = bsy_c; wd = wd_c; end
      default: begin so = so_a; rdy = rdy_a; bsy = bsy_a; wd = wd_a; end
    endcase
  end

  // Bookkeeping
  int errors = 0;
  int checks = 0;

  // Reference model state
  int         cfg_n, cfg_p;
  bit         cfg_msb;
  logic       cfg_idle;
  bit         line_q[$];
  logic [7:0] m_hold;
  bit         m_hold_full;
  bit         m_done;
  bit         m_acc;

  // Per-phase observations
  int          step_no, busy_cnt, done_cnt, runs, wd_step;
  bit          prev_busy;
  logic [31:0] cap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    line_q.delete();
    m_hold_full = 1'b0;
    m_done      = 1'b0;
    m_acc       = 1'b0;
  endtask

  task automatic model_load(input logic [7:0] w);
    for (int b = 0; b < cfg_n; b++) begin
      bit bv;
      bv = cfg_msb ? w[cfg_n-1-b] : w[b];
      for (int k = 0; k < cfg_p; k++) line_q.push_back(bv);
    end
  endtask

  // One rising edge of the line as described by the handshake/streaming rules.
  task automatic model_edge(input logic v, input logic [7:0] d, input logic f);
    bit ready_before;
    ready_before = !m_hold_full;
    m_done = 1'b0;
    m_acc  = 1'b0;
    if (f) begin
      line_q.delete();
      m_hold_full = 1'b0;
    end else begin
      if (line_q.size() == 0) begin
        if (m_hold_full) begin
          model_load(m_hold);
          m_hold_full = 1'b0;
        end
      end else begin
        void'(line_q.pop_front());
        if (line_q.size() == 0) begin
          m_done = 1'b1;
          if (m_hold_full) begin
            model_load(m_hold);
            m_hold_full = 1'b0;
          end
        end
      end
      if (v && ready_before) begin
        m_hold      = d;
        m_hold_full = 1'b1;
        m_acc       = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic exp_so;
    exp_so = (line_q.size() != 0) ? logic'(line_q[0]) : cfg_idle;
    check("serial_out", so, exp_so);
    check("busy", bsy, logic'(line_q.size() != 0));
    check("data_ready", rdy, logic'(!m_hold_full));
    check("word_done", wd, logic'(m_done));
  endtask

  task automatic clear_obs();
    step_no = 0; busy_cnt = 0; done_cnt = 0; runs = 0; wd_step = 0;
    prev_busy = 1'b0; cap = '0;
  endtask

  // Drive at the falling edge, advance the model at the rising edge,
  // compare one time unit later.
  task automatic step(input logic v, input logic [7:0] d, input logic f);
    @(negedge clk);
    data_valid = v; data_in = d; flush = f;
    @(posedge clk);
    model_edge(v, d, f);
    #1;
    step_no++;
    check_outputs();
    if (bsy === 1'b1) begin
      busy_cnt++;
      cap = {cap[30:0], so};
      if (!prev_busy) runs++;
    end
    prev_busy = (bsy === 1'b1);
    if (wd === 1'b1) begin
      done_cnt++;
      if (wd_step == 0) wd_step = step_no;
    end
  endtask

  // Hold valid with a word until the handshake completes; returns stall count.
  task automatic send_word(input logic [7:0] d, output int stalls);
    stalls = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b1, d, 1'b0);
      if (m_acc) break;
      stalls++;
    end
    if (!m_acc) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed=not_accepted expected=accepted word=%0h", d);
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic start_phase(input int s, input int n, input bit msb, input int p, input logic idle);
    @(negedge clk);
    data_valid = 1'b0; flush = 1'b0; data_in = 8'h00;
    n_rst = 1'b0;
    sel = s; cfg_n = n; cfg_msb = msb; cfg_p = p; cfg_idle = idle;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    n_rst = 1'b1;
    clear_obs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int st;
    n_rst = 1'b1; data_valid = 1'b0; flush = 1'b0; data_in = 8'h00;
    sel = 0; cfg_n = 8; cfg_msb = 1'b1; cfg_p = 1; cfg_idle = 1'b1;
    model_reset();
    clear_obs();

    // Power-on reset asserted mid-cycle, checked during and after.
    #2 n_rst = 1'b0;
    #1 check("por_serial", so_a, 1'b1);
    check("por_ready", rdy_a, 1'b1);
    check("por_busy", bsy_a, 1'b0);
    check("por_word_done", wd_a, 1'b0);
    @(negedge clk) n_rst = 1'b1;
    idle_steps(2);

    // Single word A5, MSB first.
    start_phase(0, 8, 1'b1, 1, 1'b1);
    send_word(8'hA5, st);
    idle_steps(12);
    check("a5_bits", cap[7:0], 8'hA5);
    check("a5_busy_cycles", busy_cnt, 8);
    check("a5_done_count", done_cnt, 1);
    check("a5_done_step", wd_step, 10);

    // LSB first with three clocks per bit.
    start_phase(1, 8, 1'b0, 3, 1'b1);
    send_word(8'h01, st);
    idle_steps(30);
    check("lsb_bits", cap[23:0], 24'hE00000);
    check("lsb_busy_cycles", busy_cnt, 24);
    check("lsb_done_count", done_cnt, 1);
    check("lsb_done_step", wd_step, 26);

    // Back-to-back F0 then 0F with valid held high.
    start_phase(0, 8, 1'b1, 1, 1'b1);
    send_word(8'hF0, st);
    send_word(8'h0F, st);
    check("b2b_stall", st, 1);
    idle_steps(20);
    check("b2b_bits", cap[15:0], 16'hF00F);
    check("b2b_busy_cycles", busy_cnt, 16);
    check("b2b_busy_runs", runs, 1);
    check("b2b_done_count", done_cnt, 2);

    // Holding buffer full: third word waits for the first to finish.
    start_phase(0, 8, 1'b1, 1, 1'b1);
    send_word(8'h3C, st);
    send_word(8'hC3, st);
    send_word(8'h99, st);
    check("full_third_stall", st, 7);
    idle_steps(30);
    check("full_bits", cap[23:0], 24'h3CC399);
    check("full_busy_runs", runs, 1);
    check("full_done_count", done_cnt, 3);

    // Flush at bit 3 of 00, then flush colliding with an accept.
    start_phase(0, 8, 1'b1, 1, 1'b1);
    send_word(8'h00, st);
    idle_steps(4);
    step(1'b0, 8'h00, 1'b1);
    check("flush_serial", so, 1'b1);
    check("flush_busy", bsy, 1'b0);
    check("flush_ready", rdy, 1'b1);
    check("flush_word_done", wd, 1'b0);
    step(1'b1, 8'hFF, 1'b1);
    check("flush_drops_accept", rdy, 1'b1);
    idle_steps(12);
    check("flush_done_count", done_cnt, 0);
    check("flush_busy_after", busy_cnt, 4);

    // Asynchronous reset in the middle of a bit.
    start_phase(0, 8, 1'b1, 1, 1'b1);
    send_word(8'h00, st);
    idle_steps(4);
    #1 n_rst = 1'b0;
    #1;
    model_reset();
    check("arst_serial", so, 1'b1);
    check("arst_busy", bsy, 1'b0);
    check("arst_ready", rdy, 1'b1);
    check("arst_word_done", wd, 1'b0);
    @(negedge clk) n_rst = 1'b1;
    idle_steps(12);
    check("arst_done_count", done_cnt, 0);

    // Randomized traffic on every configuration.
    for (int s = 0; s < 3; s++) begin
      case (s)
        0:       start_phase(0, 8, 1'b1, 1, 1'b1);
        1:       start_phase(1, 8, 1'b0, 3, 1'b1);
        default: start_phase(2, 5, 1'b1, 2, 1'b0);
      endcase
      for (int i = 0; i < 250; i++) begin
        step(logic'($urandom_range(0, 3) != 0), 8'($urandom),
             logic'($urandom_range(0, 40) == 0));
      end
      idle_steps(40);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
